// File: rtl/inst_line_fill_pkg.sv
// Shared constants and types for the instruction-cache line-fill engine.
package inst_line_fill_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned LINE_W     = WORD_W * LINE_WORDS;

    // A 32-byte line: byte offset is addr[4:0], tag is addr[31:5].
    localparam int unsigned OFFS_W = 5;
    localparam int unsigned TAG_W  = ADDR_W - OFFS_W;
    localparam int unsigned CNT_W  = 3;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/inst_line_fill.sv
// Line-fill engine: fetches 8 sequential words over a req/gnt/rvalid bus,
// assembles a 256-bit line, and keeps a one-entry last-line buffer.
module inst_line_fill
    import inst_line_fill_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic [LINE_W-1:0] line_data,
    output logic              line_valid,
    output logic              busy,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [WORD_W-1:0] bus_rdata
);

    state_e            state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    tag_t              tag_q, tag_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              buf_valid_q, buf_valid_d;
    tag_t              buf_tag_q, buf_tag_d;
    logic              miss_q, miss_d;
    logic              flush_seen_q, flush_seen_d;

    // Byte offset within the line is irrelevant to a line request.
    logic unused_offs;
    assign unused_offs = ^req_addr[OFFS_W-1:0];

    // State register and datapath flops; synchronous reset clears everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tag_q        <= '0;
            line_q       <= '0;
            buf_valid_q  <= 1'b0;
            buf_tag_q    <= '0;
            miss_q       <= 1'b0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            line_q       <= line_d;
            buf_valid_q  <= buf_valid_d;
            buf_tag_q    <= buf_tag_d;
            miss_q       <= miss_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    // Next-state logic, word assembly and last-line buffer update.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tag_d        = tag_q;
        line_d       = line_q;
        buf_valid_d  = buf_valid_q;
        buf_tag_d    = buf_tag_q;
        miss_d       = miss_q;
        flush_seen_d = flush_seen_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    tag_d = req_addr[ADDR_W-1:OFFS_W];
                    if (!flush && buf_valid_q &&
                        (req_addr[ADDR_W-1:OFFS_W] == buf_tag_q)) begin
                        miss_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d        = '0;
                        miss_d       = 1'b1;
                        flush_seen_d = flush;
                        state_d      = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (bus_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus_rvalid) begin
                    for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            line_d[k*WORD_W +: WORD_W] = bus_rdata;
                        end
                    end
                    if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                if (miss_q && !flush_seen_q) begin
                    buf_tag_d   = tag_q;
                    buf_valid_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A flush anywhere during a fill taints the line for buffering.
        if (flush && ((state_q == ST_REQ) || (state_q == ST_WAIT))) begin
            flush_seen_d = 1'b1;
        end
        // Flush overrides any buffer update made above, including in DONE.
        if (flush) begin
            buf_valid_d = 1'b0;
        end
    end

    // Outputs decoded from state; bus_addr is driven only while requesting.
    always_comb begin
        line_data  = line_q;
        line_valid = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE);
        bus_req    = (state_q == ST_REQ);
        bus_addr   = '0;
        if (state_q == ST_REQ) begin
            bus_addr = {tag_q, cnt_q, 2'b00};
        end
    end

endmodule

// File: tb/tb_inst_line_fill.sv
// Directed, table-driven bench for inst_line_fill with a small bus responder.
module tb_inst_line_fill;

    logic         CLK = 1'b0;
    logic         RST;
    logic         req;
    logic [31:0]  req_addr;
    logic         flush;
    logic [255:0] line_data;
    logic         line_valid;
    logic         busy;
    logic         bus_req;
    logic [31:0]  bus_addr;
    logic         bus_gnt;
    logic         bus_rvalid;
    logic [31:0]  bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    inst_line_fill dut (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .req_addr   (req_addr),
        .flush      (flush),
        .line_data  (line_data),
        .line_valid (line_valid),
        .busy       (busy),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 CLK = ~CLK;

    // Edge counter used to measure request-to-valid latency.
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] dbase;
        int          gd_word;
        int          gd;
        int          rd_word;
        int          rd;
        int          flush_at;
        bit          flush_w_req;
        bit          pre_flush;
        bit          exp_hit;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] dbase);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = dbase + 32'(k);
        return l;
    endfunction

    // Issue one line request and act as the bus until the line is delivered.
    task automatic do_req(input vec_t v, input bit spurious);
        int n, w, wc, pend, pulses, nbus, lat, gdel, rdel;
        logic [31:0] exp_ba;
        if (v.pre_flush) begin
            flush = 1'b1;
            @(negedge CLK);
            flush = 1'b0;
        end
        if (spurious) begin
            for (int j = 0; j < 2; j++) begin
                bus_rvalid = 1'b1;
                bus_rdata  = 32'hBAD0_0000 + 32'(j);
                @(negedge CLK);
            end
            bus_rvalid = 1'b0;
        end
        req      = 1'b1;
        req_addr = v.addr;
        flush    = v.flush_w_req;
        n        = cyc + 1;
        @(negedge CLK);
        req      = 1'b0;
        flush    = 1'b0;
        req_addr = 32'hFFFF_FFFF;
        w = 0; wc = 0; pend = 0; pulses = 0; nbus = 0; lat = -1;
        for (int i = 1; i <= 80; i++) begin
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            bus_rdata  = 32'hDEAD_0000 + 32'(i);
            flush      = (i == v.flush_at);
            gdel = (w == v.gd_word) ? v.gd : 0;
            rdel = (w == v.rd_word) ? v.rd : 0;
            if (bus_req) begin
                exp_ba = (v.addr & ~32'h1F) + 32'(4 * w);
                check("bus_addr", 256'(bus_addr), 256'(exp_ba));
                if (spurious) bus_rvalid = 1'b1;
                if (wc == gdel) begin
                    bus_gnt = 1'b1;
                    pend = 1; wc = 0; nbus++;
                end else begin
                    wc++;
                end
            end else if (pend != 0) begin
                if (wc == rdel) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = v.dbase + 32'(w);
                    pend = 0; wc = 0; w++;
                end else begin
                    wc++;
                end
            end
            if (line_valid) begin
                pulses++;
                if (pulses == 1) begin
                    lat = cyc + 1 - n;
                    check("line_data", line_data, mk_line(v.dbase));
                    check("busy_in_done", 256'(busy), 256'(1));
                end
            end
            if (lat >= 0 && !line_valid) break;
            @(negedge CLK);
        end
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        flush      = 1'b0;
        check("latency", 256'(lat), 256'(v.exp_lat));
        check("valid_pulses", 256'(pulses), 256'(1));
        check("bus_words", 256'(nbus), 256'(v.exp_hit ? 0 : 8));
        check("busy_idle", 256'(busy), 256'(0));
    endtask

    initial begin
        vec_t rv;
        int w, pend, seen_valid, seen_req;

        // addr, dbase, gd_word, gd, rd_word, rd, flush_at, flush_w_req, pre_flush, exp_hit, exp_lat
        vecs[0] = '{32'h0000_1234, 32'h1000, -1, 0, -1, 0, 0, 1'b0, 1'b0, 1'b0, 17};
        vecs[1] = '{32'h0000_1234, 32'h1000, -1, 0, -1, 0, 0, 1'b0, 1'b0, 1'b1, 1};
        vecs[2] = '{32'h0000_3000, 32'h3000,  2, 3,  5, 2, 0, 1'b0, 1'b0, 1'b0, 22};
        vecs[3] = '{32'h0000_2000, 32'h2000, -1, 0, -1, 0, 5, 1'b0, 1'b0, 1'b0, 17};
        vecs[4] = '{32'h0000_2000, 32'h2100, -1, 0, -1, 0, 0, 1'b0, 1'b0, 1'b0, 17};
        vecs[5] = '{32'h0000_201C, 32'h2100, -1, 0, -1, 0, 0, 1'b0, 1'b0, 1'b1, 1};
        vecs[6] = '{32'h0000_201C, 32'h2200, -1, 0, -1, 0, 0, 1'b1, 1'b0, 1'b0, 17};
        vecs[7] = '{32'h0000_2000, 32'h2300, -1, 0, -1, 0, 0, 1'b0, 1'b0, 1'b0, 17};
        vecs[8] = '{32'h0000_2008, 32'h2300, -1, 0, -1, 0, 0, 1'b0, 1'b0, 1'b1, 1};
        vecs[9] = '{32'h0000_2000, 32'h2400, -1, 0, -1, 0, 0, 1'b0, 1'b1, 1'b0, 17};

        RST = 1'b1; req = 1'b0; req_addr = '0; flush = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (3) @(negedge CLK);
        check("rst_line_data", line_data, '0);
        check("rst_outputs", 256'({line_valid, busy, bus_req, bus_addr}), '0);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i], 1'b0);
            @(negedge CLK);
        end

        // Reset while waiting for word 4 of a fill.
        req = 1'b1; req_addr = 32'h0000_4000;
        @(negedge CLK);
        req = 1'b0;
        w = 0; pend = 0;
        for (int i = 0; i < 40; i++) begin
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            if (bus_req) begin
                bus_gnt = 1'b1; pend = 1;
            end else if (pend != 0) begin
                if (w == 4) break;
                bus_rvalid = 1'b1; bus_rdata = 32'h4000 + 32'(w);
                pend = 0; w++;
            end
            @(negedge CLK);
        end
        check("wait_word4_reached", 256'(w), 256'(4));
        RST = 1'b1; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_line_data", line_data, '0);
        check("midrst_outputs", 256'({line_valid, busy, bus_req, bus_addr}), '0);
        seen_valid = 0; seen_req = 0;
        for (int i = 0; i < 10; i++) begin
            bus_rvalid = 1'b1; bus_rdata = 32'h4004;
            @(negedge CLK);
            if (line_valid) seen_valid++;
            if (bus_req) seen_req++;
        end
        bus_rvalid = 1'b0;
        check("midrst_no_valid", 256'(seen_valid), '0);
        check("midrst_no_busreq", 256'(seen_req), '0);
        rv = '{32'h0000_2000, 32'h2500, -1, 0, -1, 0, 0, 1'b0, 1'b0, 1'b0, 17};
        do_req(rv, 1'b0);
        @(negedge CLK);

        // Spurious rvalid in IDLE and REQ, with a one-cycle req.
        rv = '{32'h0000_5010, 32'h5000, -1, 0, -1, 0, 0, 1'b0, 1'b0, 1'b0, 17};
        do_req(rv, 1'b1);
        @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
